riscv_core_icache_refill_axi: RTL



---
 rtl/riscv_core_icache_pkg.sv | 16 +
 rtl/riscv_core_line_assembler.sv | 34 +++
 rtl/riscv_core_icache_refill_axi.sv | 106 ++++++++++
 3 files changed

// File: rtl/riscv_core_icache_pkg.sv
// Shared types and AXI constants for the I-cache line refill engine.
package riscv_core_icache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } refill_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int         LINE_BYTES     = 32;
  localparam int         OFFSET_BITS    = 5;

endpackage

// File: rtl/riscv_core_line_assembler.sv
// Beat counter plus word-slot line register; beat k lands in word k of the line.
module riscv_core_line_assembler #(
  parameter int  LINE_WIDTH = 256,
  parameter int  DATA_WIDTH = 32,
  localparam int BEATS      = LINE_WIDTH / DATA_WIDTH,
  localparam int CNT_W      = $clog2(BEATS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clear,
  input  logic                  i_beat_valid,
  input  logic [DATA_WIDTH-1:0] i_beat_data,
  output logic [LINE_WIDTH-1:0] o_line,
  output logic [CNT_W-1:0]      o_count,
  output logic                  o_last
);

  // Clear only rewinds the counter so the previous line stays readable
  // until the first beat of the next refill overwrites word 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_line  <= '0;
      o_count <= '0;
    end else if (i_clear) begin
      o_count <= '0;
    end else if (i_beat_valid) begin
      o_line[o_count*DATA_WIDTH +: DATA_WIDTH] <= i_beat_data;
      o_count <= o_count + 1'b1;
    end
  end

  assign o_last = (o_count == CNT_W'(BEATS - 1));

endmodule

// File: rtl/riscv_core_icache_refill_axi.sv
// I-cache refill responder: one AXI4 INCR read burst per 32-byte line request.
// Handshake: a beat or address transfers on the rising edge where valid && ready.
module riscv_core_icache_refill_axi
  import riscv_core_icache_pkg::*;
#(
  parameter int         ADDR_WIDTH     = 32,
  parameter int         LINE_WIDTH     = 256,
  parameter int         AXI_DATA_WIDTH = 32,
  parameter logic [3:0] AXI_ID         = 4'h0,
  localparam int        BEATS          = LINE_WIDTH / AXI_DATA_WIDTH,
  localparam int        CNT_W          = $clog2(BEATS)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_mem_req,
  input  logic [ADDR_WIDTH-1:0]     i_addr,
  output logic                      o_mem_done,
  output logic [LINE_WIDTH-1:0]     o_line_data,
  output logic                      o_bus_err,
  output logic                      o_busy,
  output logic [ADDR_WIDTH-1:0]     o_araddr,
  output logic [7:0]                o_arlen,
  output logic [2:0]                o_arsize,
  output logic [1:0]                o_arburst,
  output logic [3:0]                o_arid,
  output logic                      o_arvalid,
  input  logic                      i_arready,
  input  logic [AXI_DATA_WIDTH-1:0] i_rdata,
  input  logic [1:0]                i_rresp,
  input  logic                      i_rlast,
  input  logic                      i_rvalid,
  output logic                      o_rready,
  output logic [1:0]                o_dbg_state,
  output logic [CNT_W-1:0]          o_dbg_beat_cnt
);

  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    {{(ADDR_WIDTH-OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

  refill_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic                  bus_err_q;
  logic                  req_accept;
  logic                  beat_accept;
  logic                  beat_last;
  logic [CNT_W-1:0]      beat_cnt;

  assign req_accept  = (state_q == ST_IDLE) && i_mem_req;
  assign beat_accept = (state_q == ST_DATA) && i_rvalid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      araddr_q  <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (req_accept) begin
        araddr_q <= i_addr & LINE_MASK;
      end
      // RLAST is checked against our own count; the burst length is ours, not the slave's.
      if (beat_accept && ((i_rresp != AXI_RESP_OKAY) || (i_rlast != beat_last))) begin
        bus_err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_mem_req)              state_d = ST_ADDR;
      ST_ADDR: if (i_arready)              state_d = ST_DATA;
      ST_DATA: if (i_rvalid && beat_last)  state_d = ST_DONE;
      ST_DONE:                             state_d = ST_IDLE;
      default:                             state_d = ST_IDLE;
    endcase
  end

  riscv_core_line_assembler #(
    .LINE_WIDTH (LINE_WIDTH),
    .DATA_WIDTH (AXI_DATA_WIDTH)
  ) u_line_asm (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clear      (req_accept),
    .i_beat_valid (beat_accept),
    .i_beat_data  (i_rdata),
    .o_line       (o_line_data),
    .o_count      (beat_cnt),
    .o_last       (beat_last)
  );

  assign o_arvalid      = (state_q == ST_ADDR);
  assign o_rready       = (state_q == ST_DATA);
  assign o_mem_done     = (state_q == ST_DONE);
  assign o_busy         = (state_q != ST_IDLE);
  assign o_bus_err      = bus_err_q;
  assign o_araddr       = araddr_q;
  assign o_arlen        = 8'(BEATS - 1);
  assign o_arsize       = 3'($clog2(AXI_DATA_WIDTH / 8));
  assign o_arburst      = AXI_BURST_INCR;
  assign o_arid         = AXI_ID;
  assign o_dbg_state    = state_q;
  assign o_dbg_beat_cnt = beat_cnt;

endmodule
